// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory controller and its storage array.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } imem_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2
    } imem_err_e;

    localparam int unsigned IMEM_MAX_LATENCY = 15;

    // Misalignment wins over range so a bad low-order address is always reported as such.
    function automatic imem_err_e classify_addr(input logic [31:0] addr,
                                                input int unsigned addr_width);
        if (addr[1:0] != 2'b00) begin
            return ERR_MISALIGN;
        end
        if ((addr >> (addr_width + 2)) != 32'd0) begin
            return ERR_RANGE;
        end
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage with a registered, enable-gated read sample.
// Optional byte-masked write port when IMEM_WRITE_PORT_EN is defined.
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter string       INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
`ifdef IMEM_WRITE_PORT_EN
    ,
    input  logic                    wr_en,
    input  logic [31:0]             wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_comb begin
        rd_data_d = rd_en ? mem[rd_addr] : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

`ifdef IMEM_WRITE_PORT_EN
    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

    logic                  wr_ok;
    logic [ADDR_WIDTH-1:0] wr_idx;

    always_comb begin
        wr_ok  = wr_en && (classify_addr(wr_addr, ADDR_WIDTH) == ERR_NONE);
        wr_idx = wr_addr[ADDR_WIDTH+1:2];
    end

    // Nonblocking write means a read sampled on the same edge still returns the old word.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end
`endif

endmodule

// File: rtl/imem_ctrl.sv
// Handshaked instruction fetch memory: request/response FSM, wait-state counter and address checks.
// Define IMEM_WRITE_PORT_EN to expose the loader write port.
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LATENCY    = 1,
    parameter string       INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_err
`ifdef IMEM_WRITE_PORT_EN
    ,
    input  logic                    wr_en,
    input  logic [31:0]             wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb
`endif
);

    imem_state_e           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    imem_err_e             rsp_err_q, rsp_err_d;
    imem_err_e             pend_err_q, pend_err_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;

    imem_err_e             req_err;
    logic                  ready;
    logic                  accept;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    always_comb begin
        req_err = classify_addr(req_addr, ADDR_WIDTH);
        case (state_q)
            IDLE:    ready = !flush;
            RESP:    ready = rsp_ready && !flush;
            default: ready = 1'b0;
        endcase
        accept = req_valid && ready;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        pend_err_d  = pend_err_q;
        pend_addr_d = pend_addr_q;
        rd_en       = 1'b0;
        rd_addr     = pend_addr_q;

        if (flush) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
            cnt_d       = 4'd0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = pend_err_q;
                        rd_en       = (pend_err_q == ERR_NONE);
                        cnt_d       = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_d     = IDLE;
                        rsp_valid_d = 1'b0;
                    end
                end
                default: ;
            endcase

            // A new accept overrides the plain return to IDLE, giving back-to-back fetches.
            if (accept) begin
                if (LATENCY > 1) begin
                    state_d     = WAIT;
                    cnt_d       = 4'(LATENCY - 1);
                    rsp_valid_d = 1'b0;
                    pend_err_d  = req_err;
                    pend_addr_d = req_addr[ADDR_WIDTH+1:2];
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = req_err;
                    rd_en       = (req_err == ERR_NONE);
                    rd_addr     = req_addr[ADDR_WIDTH+1:2];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= ERR_NONE;
            pend_err_q  <= ERR_NONE;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            pend_err_q  <= pend_err_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    imem_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
`ifdef IMEM_WRITE_PORT_EN
        ,
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_strb(wr_strb)
`endif
    );

    assign req_ready = ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    // Errored responses never expose stale array contents.
    assign rsp_data  = (rsp_err_q == ERR_NONE) ? rd_data : '0;

endmodule
